// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB byte-memory slave.
package apb_pkg;

  localparam int unsigned DefaultDataW    = 8;
  localparam int unsigned DefaultAddrW    = 8;
  localparam int unsigned DefaultMemDepth = 64;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } apb_state_e;

endpackage

// File: rtl/apb_mem.sv
// Byte storage with asynchronous clear, one write port and a combinational read port.
module apb_mem #(
  parameter int unsigned DataW = 8,
  parameter int unsigned Depth = 64,
  parameter int unsigned AddrW = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] mem_d [Depth];

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave.sv
// APB slave fronting a small byte memory: setup/access FSM, programmable wait states,
// error response for addresses beyond the implemented depth.
module apb_slave
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W      = DefaultDataW,
  parameter int unsigned ADDR_W      = DefaultAddrW,
  parameter int unsigned MEM_DEPTH   = DefaultMemDepth,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR
);

  localparam int unsigned      MemAw  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0]  DepthL = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [3:0]       WaitL  = 4'(WAIT_STATES);

  apb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              in_range;
  logic              complete;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign in_range = {1'b0, addr_q} < DepthL;
  assign PREADY   = (state_q == StAccess) && (cnt_q == WaitL);
  assign complete = PREADY && PSEL && PENABLE;
  assign mem_we   = complete && wr_q && in_range;
  assign PSLVERR  = PREADY && !in_range;
  assign PRDATA   = (PREADY && !wr_q && in_range) ? mem_rdata : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        // A bare PENABLE without a preceding setup phase is ignored here.
        if (PSEL && !PENABLE) begin
          state_d = StSetup;
          addr_d  = PADDR;
          wr_d    = PWRITE;
          wdata_d = PWDATA;
        end
      end
      StSetup: begin
        if (!PSEL) begin
          state_d = StIdle;
        end else if (PENABLE) begin
          state_d = StAccess;
          cnt_d   = '0;
        end else begin
          addr_d  = PADDR;
          wr_d    = PWRITE;
          wdata_d = PWDATA;
        end
      end
      StAccess: begin
        // Completion returns to idle; a following setup is caught there on the next edge,
        // so back-to-back transfers need no idle bus cycle.
        if (!PSEL) begin
          state_d = StIdle;
        end else if (PREADY) begin
          if (PENABLE) begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  apb_mem #(
    .DataW(DATA_W),
    .Depth(MEM_DEPTH),
    .AddrW(MemAw)
  ) u_mem (
    .clk_i  (clk),
    .rst_ni (PRESETn),
    .we_i   (mem_we),
    .waddr_i(addr_q[MemAw-1:0]),
    .wdata_i(wdata_q),
    .raddr_i(addr_q[MemAw-1:0]),
    .rdata_o(mem_rdata)
  );

endmodule

// File: tb/tb_apb_slave.sv
// Randomized scoreboard bench for apb_slave: three instances with 0, 1 and 3 wait states.
module tb_apb_slave;

  localparam int NDut  = 3;
  localparam int Depth = 64;

  logic       clk = 1'b0;
  logic       presetn;
  logic       psel    [NDut];
  logic       penable [NDut];
  logic       pwrite  [NDut];
  logic [7:0] paddr   [NDut];
  logic [7:0] pwdata  [NDut];
  logic       pready  [NDut];
  logic [7:0] prdata  [NDut];
  logic       pslverr [NDut];

  always #5 clk = ~clk;

  apb_slave #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PREADY(pready[0]), .PRDATA(prdata[0]),
    .PSLVERR(pslverr[0])
  );
  apb_slave #(.WAIT_STATES(1)) u_dut1 (
    .clk(clk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PREADY(pready[1]), .PRDATA(prdata[1]),
    .PSLVERR(pslverr[1])
  );
  apb_slave #(.WAIT_STATES(3)) u_dut2 (
    .clk(clk), .PRESETn(presetn), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PREADY(pready[2]), .PRDATA(prdata[2]),
    .PSLVERR(pslverr[2])
  );

  typedef struct {
    int         d;
    logic [7:0] rdata;
    logic       err;
    int         low;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model [NDut][Depth];
  int         npass  = 0;
  int         ntotal = 0;
  int         lowcnt [NDut];

  function automatic int ws_of(input int d);
    case (d)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    ntotal++;
    if (act === req) npass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endtask

  task automatic clear_model();
    for (int d = 0; d < NDut; d++)
      for (int a = 0; a < Depth; a++) model[d][a] = 8'h00;
  endtask

  task automatic idle_bus();
    for (int d = 0; d < NDut; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
    end
  endtask

  // Reference: every completed transfer takes WAIT_STATES+1 PREADY-low access cycles;
  // in-range writes update the byte, out-of-range accesses error with zero data.
  task automatic push_exp(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd);
    exp_t e;
    e.d   = d;
    e.err = (a >= Depth);
    e.low = ws_of(d) + 1;
    e.rdata = 8'h00;
    if (!e.err) begin
      if (wr) model[d][a] = wd;
      else    e.rdata = model[d][a];
    end
    exp_q.push_back(e);
  endtask

  // abort_at: access cycle (1-based) in which PSEL is dropped; 0 for none.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                      input int abort_at);
    bit done = 0;
    bit aborted = 0;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    if (abort_at == 0) push_exp(d, wr, a, wd);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (c == abort_at) begin
        psel[d] = 1'b0; penable[d] = 1'b0;
        @(posedge clk); #1;
        aborted = 1;
        break;
      end
      if (c >= 2) begin
        paddr[d] = 8'($urandom); pwdata[d] = 8'($urandom); pwrite[d] = 1'($urandom);
      end
      @(negedge clk);
      if (pready[d]) begin
        @(posedge clk); #1;
        done = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done && !aborted) begin
      ntotal++;
      $display("FAIL xfer_timeout: dut %0d addr %0h got no PREADY required PREADY", d, a);
    end
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  // Monitor: compare every completion against the scoreboard; outputs idle at zero otherwise.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < NDut; d++) begin
      if (!presetn) begin
        lowcnt[d] = 0;
      end else begin
        if (!pready[d]) begin
          chk("idle_prdata", 32'(prdata[d]), 32'h0);
          chk("idle_pslverr", 32'(pslverr[d]), 32'h0);
        end
        if (psel[d] && penable[d]) begin
          if (pready[d]) begin
            if (exp_q.size() == 0) begin
              ntotal++;
              $display("FAIL unexpected_completion: dut %0d got PREADY required none", d);
            end else begin
              e = exp_q.pop_front();
              chk("dut_index", 32'(d), 32'(e.d));
              chk("prdata", 32'(prdata[d]), 32'(e.rdata));
              chk("pslverr", 32'(pslverr[d]), 32'(e.err));
              chk("wait_cycles", 32'(lowcnt[d]), 32'(e.low));
            end
            lowcnt[d] = 0;
          end else begin
            lowcnt[d] = lowcnt[d] + 1;
          end
        end else begin
          lowcnt[d] = 0;
        end
      end
    end
  end

  initial begin
    int d, gap, ab;
    bit wr;
    logic [7:0] a;

    presetn = 1'b0;
    idle_bus();
    clear_model();
    for (int i = 0; i < NDut; i++) lowcnt[i] = 0;
    #1;
    for (int i = 0; i < NDut; i++) begin
      chk("rst_pready", 32'(pready[i]), 32'h0);
      chk("rst_prdata", 32'(prdata[i]), 32'h0);
      chk("rst_pslverr", 32'(pslverr[i]), 32'h0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    presetn = 1'b1;

    // First setup right after release, then write/read with one wait state.
    xfer(1, 1, 8'h10, 8'hA5, 0);
    xfer(1, 0, 8'h10, 8'h00, 0);

    // Zero wait states, back-to-back.
    xfer(0, 1, 8'h05, 8'h3C, 0);
    xfer(0, 0, 8'h05, 8'h00, 0);

    // Out-of-range write leaves memory alone (0x40 must not alias onto 0x00).
    xfer(1, 1, 8'h40, 8'hFF, 0);
    xfer(1, 0, 8'h40, 8'h00, 0);
    xfer(1, 0, 8'h00, 8'h00, 0);

    // Abort in the second ACCESS cycle with three wait states.
    xfer(2, 1, 8'h01, 8'h77, 3);
    @(negedge clk);
    chk("abort_pready", 32'(pready[2]), 32'h0);
    xfer(2, 0, 8'h01, 8'h00, 0);

    // PENABLE without a setup phase.
    psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 8'h20; pwdata[1] = 8'h99;
    repeat (3) begin
      @(negedge clk);
      chk("nosetup_pready", 32'(pready[1]), 32'h0);
    end
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    xfer(1, 0, 8'h20, 8'h00, 0);

    // Reset while a write is presenting PREADY but before its commit edge.
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'h02; pwdata[2] = 8'h12;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("prerst_pready", 32'(pready[2]), 32'h1);
    presetn = 1'b0;
    #1;
    chk("asyncrst_pready", 32'(pready[2]), 32'h0);
    chk("asyncrst_prdata", 32'(prdata[2]), 32'h0);
    chk("asyncrst_pslverr", 32'(pslverr[2]), 32'h0);
    idle_bus();
    clear_model();
    @(negedge clk);
    @(negedge clk);
    presetn = 1'b1;
    xfer(2, 0, 8'h02, 8'h00, 0);
    xfer(1, 0, 8'h10, 8'h00, 0);

    // Randomized traffic across all three instances.
    for (int n = 0; n < 300; n++) begin
      d  = int'($urandom_range(0, NDut - 1));
      wr = 1'($urandom);
      if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(64, 255));
      else                           a = 8'($urandom_range(0, 63));
      ab = 0;
      if ($urandom_range(0, 9) == 0) ab = int'($urandom_range(1, ws_of(d) + 1));
      xfer(d, wr, a, 8'($urandom), ab);
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width.
REQ-002 SHALL have parameter ADDR_W, default 8, slave-local address width; bus bit 8 is decoded upstream into PSEL.
REQ-003 SHALL have parameter MEM_DEPTH, default 64, number of implemented bytes.
REQ-004 SHALL have parameter WAIT_STATES, default 1, PREADY-low cycles per access (0..15).
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port PRESETn, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port PSEL, input, 1, slave selected.
REQ-008 SHALL have port PENABLE, input, 1, access phase.
REQ-009 SHALL have port PWRITE, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port PADDR, input, ADDR_W, byte address.
REQ-011 SHALL have port PWDATA, input, DATA_W, write data.
REQ-012 SHALL have port PREADY, output, 1, transfer completes this cycle.
REQ-013 SHALL have port PRDATA, output, DATA_W, read data.
REQ-014 SHALL have port PSLVERR, output, 1, error response, valid only while PREADY=1.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-016 IDLE->SETUP on PSEL=1 & PENABLE=0; PADDR, PWRITE, PWDATA latched into addr_q, wr_q, wdata_q on that edge.
REQ-017 SETUP->ACCESS on PSEL=1 & PENABLE=1; wait counter cleared to 0.
REQ-018 SETUP->IDLE on PSEL=0; SETUP->SETUP (re-latch) on PSEL=1 & PENABLE=0.
REQ-019 In ACCESS, the counter increments each cycle until it reaches WAIT_STATES, then holds.
REQ-020 PREADY = (state==ACCESS) & (count==WAIT_STATES); zero-wait when WAIT_STATES=0.
REQ-021 On the edge sampling PSEL & PENABLE & PREADY, the transfer completes; next state is SETUP if PSEL=1 & PENABLE=0 are sampled on the following setup, otherwise IDLE; back-to-back transfers need no idle cycle.
REQ-022 Write commit: mem[addr_q] <= wdata_q on the completion edge, only if wr_q=1 and addr_q<MEM_DEPTH.
REQ-023 PRDATA = mem[addr_q] while PREADY=1 & wr_q=0 & addr_q<MEM_DEPTH; otherwise 0.
REQ-024 PSLVERR = PREADY & (addr_q>=MEM_DEPTH); the access has no memory effect and PRDATA is 0.
REQ-025 PSEL dropping in ACCESS before PREADY aborts: return to IDLE, no write, no error.
REQ-026 PENABLE=1 sampled in IDLE (no setup phase) is ignored; the FSM stays in IDLE.
REQ-027 PADDR, PWDATA and PWRITE changes during ACCESS are ignored; latched values are used.
REQ-028 Read of a location written by the immediately preceding transfer returns the new data.

Reset
REQ-029 PRESETn=0 SHALL immediately force state IDLE, counter 0, addr_q/wr_q/wdata_q 0, PREADY 0, PRDATA 0, PSLVERR 0.
REQ-030 Reset SHALL clear all MEM_DEPTH memory bytes to 0.
REQ-031 Reset mid-ACCESS SHALL abort the transfer with no write.
REQ-032 The first setup SHALL be accepted on the first rising edge after PRESETn deasserts.

Structure
REQ-033 Package apb_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS) and the default DATA_W, ADDR_W and MEM_DEPTH constants.
REQ-034 Storage SHALL be in sub-module apb_mem, containing the register array with async clear, write port and combinational read port.
REQ-035 FSM, wait counter and response logic SHALL reside in apb_slave.

Verification
REQ-036 Reset, then write 0xA5 to addr 0x10 and read 0x10, WAIT_STATES=1 -> each access shows PREADY low 1 cycle then high 1 cycle; read PRDATA=0xA5, PSLVERR=0.
REQ-037 WAIT_STATES=0, back-to-back write 0x3C@0x05 then read 0x05 with no idle cycle -> PREADY high in the first ACCESS cycle; PRDATA=0x3C.
REQ-038 Write 0xFF to addr 0x40 (=MEM_DEPTH) -> PSLVERR=1 with PREADY, memory unchanged; read 0x40 -> PRDATA=0, PSLVERR=1.
REQ-039 WAIT_STATES=3, PSEL dropped in 2nd ACCESS cycle of write 0x77@0x01 -> FSM IDLE, read 0x01 returns 0x00.
REQ-040 PRESETn pulsed low mid-ACCESS after writing 0x12@0x02 -> outputs 0 asynchronously; read 0x02 after release returns 0x00.
REQ-041 PENABLE=1 with PSEL=1 and no setup cycle -> PREADY stays 0 and no write occurs.
